mem_errdet_switch: RTL and testbench
====================================

MEM_ERRDET_SWITCH -- requirements
Module: mem_errdet_switch

Interface
REQ-001 The block SHALL have parameter NMOD, default 4: number of duplex memory module pairs; legal range 2..16.
REQ-002 The block SHALL have parameter ERR_LIMIT, default 2: counted errors on one side before that side is dropped; legal range 1..15.
REQ-003 The block SHALL have port CLK  in  1: single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST  in  1: asynchronous, active-high reset.
REQ-005 The block SHALL have port STB  in  1: one-cycle memory-access strobe; all other access inputs are valid only with it.
REQ-006 The block SHALL have port IMACC  in  1: 1 = instruction access, 0 = data access.
REQ-007 The block SHALL have port MSEL  in  $clog2(NMOD): addressed module pair.
REQ-008 The block SHALL have ports PERRA, PERRB  in  1: parity error seen on side A / side B for this access.
REQ-009 The block SHALL have port SYNC  in  1: request a module sync pulse for this access.
REQ-010 The block SHALL have port RECOVER  in  1: operator recovery request.
REQ-011 The block SHALL have ports ENA, ENB  out  1: side A / side B memory enabled.
REQ-012 The block SHALL have ports EAC, EBC  out  1: one-cycle pulse per counted error on side A / side B.
REQ-013 The block SHALL have port HALT  out  1: both sides failed.
REQ-014 The block SHALL have port MSYNC  out  NMOD: one-hot module sync pulse.
REQ-015 The block SHALL have ports CNTA_DM, CNTA_IM, CNTB_DM, CNTB_IM  out  $clog2(ERR_LIMIT+1): per-side, per-access-type error counts.

Function
REQ-016 The state machine SHALL have states DUPLEX, SIMPLEX_A (B dropped), SIMPLEX_B (A dropped) and FAILED.
REQ-017 ENA SHALL be 1 in DUPLEX and SIMPLEX_A; ENB SHALL be 1 in DUPLEX and SIMPLEX_B; HALT SHALL be 1 only in FAILED.
REQ-018 When STB=1 and the side is enabled, PERRx SHALL increment CNTx_DM (IMACC=0) or CNTx_IM (IMACC=1), saturating at ERR_LIMIT.
REQ-019 When STB=1 and the side is enabled, PERRx SHALL pulse ExC in the following cycle, including when the counter is already saturated.
REQ-020 Errors reported on a disabled side, or with STB=0, SHALL be ignored: no count, no pulse.
REQ-021 A side SHALL be failed when either of its counters equals ERR_LIMIT.
REQ-022 The state SHALL update in the cycle after the counter update, so the enable drop has 2-cycle latency from the failing STB.
REQ-023 State transitions SHALL be:
  - DUPLEX -> SIMPLEX_B when only A has failed;
  - DUPLEX -> SIMPLEX_A when only B has failed;
  - DUPLEX -> FAILED when both sides fail on the same strobe;
  - SIMPLEX_x -> FAILED when the remaining side fails;
  - FAILED is held until reset or recovery.
REQ-024 With STB=1 and SYNC=1 and the state not FAILED, MSYNC[MSEL] SHALL be 1 for exactly the next cycle and all other bits 0.
REQ-025 MSEL values >= NMOD SHALL produce no MSYNC pulse.
REQ-026 With STB=0, MSYNC SHALL be all-zero.

Reset
REQ-027 While RST=1, the block SHALL hold:
  - state DUPLEX (ENA=ENB=1, HALT=0);
  - all counters 0;
  - EAC=EBC=0;
  - MSYNC=0.
REQ-028 Reset asserted mid-access SHALL discard any pending count, pulse or sync.
REQ-029 After RST falls, the first STB SHALL be processed normally.

Configuration
REQ-030 Macro ERRDET_RECOVER_EN SHALL control the recovery feature.
REQ-031 With ERRDET_RECOVER_EN defined, RECOVER=1 for one cycle SHALL clear all counters and return the state to DUPLEX on the next edge.
REQ-032 With ERRDET_RECOVER_EN defined, RECOVER SHALL take priority over a simultaneous STB: that access is not counted and its SYNC is still honoured.
REQ-033 Without ERRDET_RECOVER_EN, the RECOVER port SHALL remain present but be ignored, and only RST restores DUPLEX.

Structure
REQ-034 Package errdet_pkg SHALL hold the state enum (DUPLEX, SIMPLEX_A, SIMPLEX_B, FAILED) and the counter-width function.
REQ-035 Sub-module errdet_side SHALL be instantiated twice (side A, side B) and SHALL contain the DM/IM saturating counters, the error pulse and the failed flag.
REQ-036 The top level SHALL hold the state machine and the MSYNC decode.

Verification
REQ-037 Defaults; reset; 5 clean STBs with SYNC=1 and MSEL=0,1,2,3,0 -> MSYNC = 0001, 0010, 0100, 1000, 0001 one cycle after each; no EAC or EBC.
REQ-038 STB with PERRA=1, IMACC=0, then a second such STB -> CNTA_DM=1, then 2; EAC pulses twice; ENA=0 two cycles after the second STB; state SIMPLEX_B.
REQ-039 In SIMPLEX_B, STB with PERRA=1 -> no count and no EAC; then two STBs with PERRB=1, IMACC=1 -> CNTB_IM=2; HALT=1; ENB=0; later SYNC STBs give MSYNC=0.
REQ-040 In DUPLEX with ERR_LIMIT=1, one STB with PERRA=PERRB=1 -> EAC and EBC pulse together; state goes directly to FAILED.
REQ-041 With ERRDET_RECOVER_EN, in FAILED, RECOVER=1 together with STB, PERRA=1, SYNC=1 and MSEL=2 -> all counters 0; DUPLEX; MSYNC=0100; no EAC. Without the macro, the state stays FAILED.
REQ-042 With NMOD=8, assert RST during a STB with PERRB=1 when CNTB_DM=1 -> CNTB_DM=0, no EBC pulse, DUPLEX after release.

Source files
------------

// File: rtl/errdet_pkg.sv
// Shared types and helpers for the duplex memory error-detect switch.
package errdet_pkg;

  typedef enum logic [1:0] {
    DUPLEX,
    SIMPLEX_A,
    SIMPLEX_B,
    FAILED
  } state_t;

  // Width of an error counter able to reach 'limit'.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/errdet_side.sv
// One memory side: DM/IM saturating error counters, counted-error pulse and
// failed flag.
module errdet_side
  import errdet_pkg::*;
#(
  parameter int unsigned ERR_LIMIT = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            hit,
  input  logic                            imacc,
  output logic [cnt_width(ERR_LIMIT)-1:0] cnt_dm,
  output logic [cnt_width(ERR_LIMIT)-1:0] cnt_im,
  output logic                            pulse,
  output logic                            failed
);

  localparam int unsigned CW = cnt_width(ERR_LIMIT);
  localparam logic [CW-1:0] LIM = CW'(ERR_LIMIT);

  // Count qualified errors per access type, saturating at the limit; pulse on every hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_dm <= '0;
      cnt_im <= '0;
      pulse  <= 1'b0;
    end else if (clr) begin
      cnt_dm <= '0;
      cnt_im <= '0;
      pulse  <= 1'b0;
    end else begin
      pulse <= hit;
      if (hit) begin
        if (imacc) begin
          if (cnt_im != LIM) cnt_im <= cnt_im + CW'(1);
        end else begin
          if (cnt_dm != LIM) cnt_dm <= cnt_dm + CW'(1);
        end
      end
    end
  end

  // Side is failed once either counter has reached the limit.
  always_comb begin
    failed = (cnt_dm == LIM) || (cnt_im == LIM);
  end

endmodule

// File: rtl/mem_errdet_switch.sv
// Duplex memory error-detect switch: per-side error counting, duplex/simplex
// state machine and one-hot module sync pulse.
// Optional feature: define ERRDET_RECOVER_EN to enable the RECOVER input.
module mem_errdet_switch
  import errdet_pkg::*;
#(
  parameter int unsigned NMOD      = 4,
  parameter int unsigned ERR_LIMIT = 2
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            STB,
  input  logic                            IMACC,
  input  logic [$clog2(NMOD)-1:0]         MSEL,
  input  logic                            PERRA,
  input  logic                            PERRB,
  input  logic                            SYNC,
  input  logic                            RECOVER,
  output logic                            ENA,
  output logic                            ENB,
  output logic                            EAC,
  output logic                            EBC,
  output logic                            HALT,
  output logic [NMOD-1:0]                 MSYNC,
  output logic [cnt_width(ERR_LIMIT)-1:0] CNTA_DM,
  output logic [cnt_width(ERR_LIMIT)-1:0] CNTA_IM,
  output logic [cnt_width(ERR_LIMIT)-1:0] CNTB_DM,
  output logic [cnt_width(ERR_LIMIT)-1:0] CNTB_IM
);

  state_t          state, state_nxt;
  logic            rec;
  logic            hit_a, hit_b;
  logic            fail_a, fail_b;
  logic            sync_ok;
  logic [NMOD-1:0] msync_nxt;

`ifdef ERRDET_RECOVER_EN
  assign rec = RECOVER;
`else
  logic recover_unused;
  assign recover_unused = RECOVER;
  assign rec = 1'b0;
`endif

  // Errors are only counted on an enabled side during a strobe; recovery wins.
  always_comb begin
    hit_a = STB && ENA && PERRA && !rec;
    hit_b = STB && ENB && PERRB && !rec;
  end

  errdet_side #(.ERR_LIMIT(ERR_LIMIT)) u_side_a (
    .clk    (CLK),
    .rst    (RST),
    .clr    (rec),
    .hit    (hit_a),
    .imacc  (IMACC),
    .cnt_dm (CNTA_DM),
    .cnt_im (CNTA_IM),
    .pulse  (EAC),
    .failed (fail_a)
  );

  errdet_side #(.ERR_LIMIT(ERR_LIMIT)) u_side_b (
    .clk    (CLK),
    .rst    (RST),
    .clr    (rec),
    .hit    (hit_b),
    .imacc  (IMACC),
    .cnt_dm (CNTB_DM),
    .cnt_im (CNTB_IM),
    .pulse  (EBC),
    .failed (fail_b)
  );

  // State register; follows the counters one cycle later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= DUPLEX;
    else     state <= state_nxt;
  end

  // Next-state logic and enable/halt decode.
  always_comb begin
    state_nxt = state;
    ENA       = 1'b0;
    ENB       = 1'b0;
    HALT      = 1'b0;
    if (rec) begin
      state_nxt = DUPLEX;
    end else begin
      case (state)
        DUPLEX: begin
          if (fail_a && fail_b) state_nxt = FAILED;
          else if (fail_a)      state_nxt = SIMPLEX_B;
          else if (fail_b)      state_nxt = SIMPLEX_A;
        end
        SIMPLEX_A: if (fail_a) state_nxt = FAILED;
        SIMPLEX_B: if (fail_b) state_nxt = FAILED;
        FAILED:    state_nxt = FAILED;
        default:   state_nxt = DUPLEX;
      endcase
    end
    case (state)
      DUPLEX:    begin ENA = 1'b1; ENB = 1'b1; end
      SIMPLEX_A: ENA = 1'b1;
      SIMPLEX_B: ENB = 1'b1;
      FAILED:    HALT = 1'b1;
      default:   begin ENA = 1'b1; ENB = 1'b1; end
    endcase
  end

  // Sync decode: a recovery strobe still syncs even though the state is FAILED.
  always_comb begin
    sync_ok   = STB && SYNC && ((state != FAILED) || rec) && (32'(MSEL) < NMOD);
    msync_nxt = '0;
    if (sync_ok) msync_nxt = NMOD'(1) << MSEL;
  end

  // One-cycle registered sync pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) MSYNC <= '0;
    else     MSYNC <= msync_nxt;
  end

endmodule

// File: tb/tb_mem_errdet_switch.sv
// Directed self-checking bench for mem_errdet_switch. Three instances share
// the access stimulus; each is held in reset until its own scenario runs.
module tb_mem_errdet_switch;

  logic       clk;
  logic       stb, imacc, perra, perrb, sync, recover;
  logic [2:0] msel;
  logic       rst1, rst2, rst3;

  // u1: defaults (NMOD=4, ERR_LIMIT=2)
  logic       ena1, enb1, eac1, ebc1, halt1;
  logic [3:0] msync1;
  logic [1:0] cad1, cai1, cbd1, cbi1;
  // u2: NMOD=8, ERR_LIMIT=3
  logic       ena2, enb2, eac2, ebc2, halt2;
  logic [7:0] msync2;
  logic [1:0] cad2, cai2, cbd2, cbi2;
  // u3: NMOD=3, ERR_LIMIT=1
  logic       ena3, enb3, eac3, ebc3, halt3;
  logic [2:0] msync3;
  logic [0:0] cad3, cai3, cbd3, cbi3;

  int checks = 0;
  int errors = 0;

  mem_errdet_switch u1 (
    .CLK(clk), .RST(rst1), .STB(stb), .IMACC(imacc), .MSEL(msel[1:0]),
    .PERRA(perra), .PERRB(perrb), .SYNC(sync), .RECOVER(recover),
    .ENA(ena1), .ENB(enb1), .EAC(eac1), .EBC(ebc1), .HALT(halt1), .MSYNC(msync1),
    .CNTA_DM(cad1), .CNTA_IM(cai1), .CNTB_DM(cbd1), .CNTB_IM(cbi1)
  );

  mem_errdet_switch #(.NMOD(8), .ERR_LIMIT(3)) u2 (
    .CLK(clk), .RST(rst2), .STB(stb), .IMACC(imacc), .MSEL(msel),
    .PERRA(perra), .PERRB(perrb), .SYNC(sync), .RECOVER(recover),
    .ENA(ena2), .ENB(enb2), .EAC(eac2), .EBC(ebc2), .HALT(halt2), .MSYNC(msync2),
    .CNTA_DM(cad2), .CNTA_IM(cai2), .CNTB_DM(cbd2), .CNTB_IM(cbi2)
  );

  mem_errdet_switch #(.NMOD(3), .ERR_LIMIT(1)) u3 (
    .CLK(clk), .RST(rst3), .STB(stb), .IMACC(imacc), .MSEL(msel[1:0]),
    .PERRA(perra), .PERRB(perrb), .SYNC(sync), .RECOVER(recover),
    .ENA(ena3), .ENB(enb3), .EAC(eac3), .EBC(ebc3), .HALT(halt3), .MSYNC(msync3),
    .CNTA_DM(cad3), .CNTA_IM(cai3), .CNTB_DM(cbd3), .CNTB_IM(cbi3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stb = 0; imacc = 0; perra = 0; perrb = 0; sync = 0; recover = 0; msel = '0;
  endtask

  // Safety net in case the run stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned mv [5];
    mv = '{0, 1, 2, 3, 0};
    idle();
    rst1 = 1; rst2 = 1; rst3 = 1;
    step();
    // strobe with sync during reset must be discarded
    stb = 1; sync = 1; msel = 3'd1;
    step();
    check("rst_ena", ena1, 1);
    check("rst_enb", enb1, 1);
    check("rst_halt", halt1, 0);
    check("rst_msync", msync1, 0);
    check("rst_eac", eac1, 0);
    check("rst_cnt", {cad1, cai1, cbd1, cbi1}, 0);
    idle();
    rst1 = 0;
    step();

    // STB=0 errors ignored
    perra = 1; perrb = 1;
    step();
    idle();
    check("nostb_eac", eac1, 0);
    check("nostb_cnt", {cad1, cbd1}, 0);

    // clean sync strobes
    for (int i = 0; i < 5; i++) begin
      msel = 3'(mv[i]); stb = 1; sync = 1;
      step();
      idle();
      check("sync_msync", msync1, 32'd1 << mv[i]);
      check("sync_eacebc", {eac1, ebc1}, 0);
    end
    step();
    check("sync_oneshot", msync1, 0);

    // two DM errors on side A
    stb = 1; perra = 1;
    step();
    idle();
    check("a1_cnt", cad1, 1);
    check("a1_eac", eac1, 1);
    step();
    check("a1_eac_off", eac1, 0);
    check("a1_ena", ena1, 1);
    stb = 1; perra = 1;
    step();
    idle();
    check("a2_cnt", cad1, 2);
    check("a2_eac", eac1, 1);
    check("a2_ena_lat", ena1, 1);
    step();
    check("a2_ena", ena1, 0);
    check("a2_enb", enb1, 1);
    check("a2_halt", halt1, 0);

    // SIMPLEX_B: side A errors ignored
    stb = 1; perra = 1; imacc = 1;
    step();
    idle();
    check("sb_eac", eac1, 0);
    check("sb_cai", cai1, 0);
    // two IM errors on B
    stb = 1; perrb = 1; imacc = 1;
    step();
    idle();
    check("b1_cbi", cbi1, 1);
    check("b1_ebc", ebc1, 1);
    stb = 1; perrb = 1; imacc = 1;
    step();
    idle();
    check("b2_cbi", cbi1, 2);
    step();
    check("fail_halt", halt1, 1);
    check("fail_en", {ena1, enb1}, 0);
    stb = 1; sync = 1; msel = 3'd1;
    step();
    idle();
    check("fail_msync", msync1, 0);

    // recovery with simultaneous strobe
    recover = 1; stb = 1; perra = 1; sync = 1; msel = 3'd2;
    step();
    idle();
`ifdef ERRDET_RECOVER_EN
    check("rec_cnt", {cad1, cai1, cbd1, cbi1}, 0);
    check("rec_msync", msync1, 4'b0100);
    check("rec_eac", eac1, 0);
    check("rec_state", {ena1, enb1, halt1}, 3'b110);
`else
    check("norec_halt", halt1, 1);
    check("norec_msync", msync1, 0);
    check("norec_cnt", cad1, 2);
`endif

    // u3: out-of-range MSEL and simultaneous double failure
    rst3 = 0;
    step();
    stb = 1; sync = 1; msel = 3'd3;
    step();
    idle();
    check("u3_msel_oor", msync3, 0);
    stb = 1; sync = 1; msel = 3'd2;
    step();
    idle();
    check("u3_msync2", msync3, 3'b100);
    stb = 1; perra = 1; perrb = 1;
    step();
    idle();
    check("u3_pulses", {eac3, ebc3}, 2'b11);
    check("u3_cnts", {cad3, cbd3}, 2'b11);
    check("u3_en_lat", {ena3, enb3, halt3}, 3'b110);
    step();
    check("u3_failed", {ena3, enb3, halt3}, 3'b001);

    // u2: NMOD=8 sync, reset during an errored strobe, first STB after reset
    rst2 = 0;
    step();
    stb = 1; sync = 1; msel = 3'd5;
    step();
    idle();
    check("u2_msync5", msync2, 8'h20);
    stb = 1; perrb = 1;
    step();
    idle();
    check("u2_cbd1", cbd2, 1);
    check("u2_ebc1", ebc2, 1);
    stb = 1; perrb = 1; rst2 = 1;
    step();
    check("u2_rst_cbd", cbd2, 0);
    check("u2_rst_ebc", ebc2, 0);
    idle();
    rst2 = 0;
    step();
    check("u2_post_ebc", ebc2, 0);
    check("u2_post_state", {ena2, enb2, halt2}, 3'b110);
    stb = 1; perrb = 1;
    step();
    idle();
    check("u2_first_cbd", cbd2, 1);
    check("u2_first_ebc", ebc2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
